decryption_counter: RTL and testbench
=====================================

Name: decryption_counter

Overview:
- Control sequencer for the AES-128 decryption datapath; the inverse-cipher counterpart of the encryption round controller.
- On start it runs a forward key-expansion pre-pass to derive round key 10.
- It then issues one-cycle strobes for AddRoundKey, InvShiftRows, InvSubBytes, inverse key step and InvMixColumns, in inverse-cipher order.
- It drives the datapath mux selects and the round constant, and pulses counter_done when plaintext is valid.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) is legal.
- CNT_W, 4, width of the round counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a decryption; sampled only in IDLE.
- kexp_start  output  1  forward key-expansion step strobe (pre-pass).
- add_start  output  1  AddRoundKey strobe.
- ishift_start  output  1  InvShiftRows strobe.
- isub_start  output  1  InvSubBytes strobe.
- ikey_start  output  1  inverse key-schedule step strobe.
- imix_start  output  1  InvMixColumns strobe.
- key_RC  output  32  round constant for the active key step, {rcon,24'h0}; 0 otherwise.
- mux1_sel  output  1  0 = AddRoundKey takes ciphertext input; 1 = takes round state.
- mux2_sel  output  2  00 initial add; 01 rounds 1-9 (state from InvMix path); 10 final round (state from InvSub path).
- round  output  4  current round counter C, 0..10.
- busy  output  1  high from the first strobe cycle through the final add_start cycle.
- counter_done  output  1  one-cycle pulse: plaintext valid.

Behaviour:
- Reset: all outputs 0, except mux1_sel=0 and mux2_sel=00. FSM to IDLE, C=0, expansion counter K=0.
- Reset mid-operation aborts immediately to the reset state; no strobe completes.
- All outputs are registered from next-state logic, so a strobe appears the cycle after its state is occupied.
- Timeline below is relative to E0, the rising edge where start=1 is sampled in IDLE. "Ex" means high during the cycle following edge Ex.
- States: IDLE, KEXP, ADD0, ISHIFT, ISUB, IKEY, ADD, IMIX, FIN. Every non-IDLE state lasts exactly one cycle.
- IDLE -> KEXP on start; otherwise stay in IDLE.
- KEXP, K=0..9:
  - kexp_start=1, key_RC = rcon[K+1], with rcon sequence 01,02,04,08,10,20,40,80,1B,36.
  - K increments each cycle; after K=9, go to ADD0.
- ADD0: add_start=1, mux1_sel=0, mux2_sel=00, C := 1. Go to ISHIFT.
- Round C (1..10):
  - ISHIFT -> ISUB -> IKEY -> ADD.
  - IKEY: ikey_start=1, key_RC = rcon[11-C] (0x36 for C=1 down to 0x01 for C=10).
  - ADD -> IMIX if C<10; ADD -> FIN if C=10.
  - IMIX: imix_start=1, C := C+1, then go to ISHIFT.
- mux1_sel=1 for all states after ADD0.
- mux2_sel=01 through rounds 1-9 and 10 during round 10. It is updated on the ISHIFT strobe of each round and held until the next.
- FIN: counter_done=1 for one cycle, busy=0. Next state IDLE, C and K cleared, mux selects return to reset values.
- start while not in IDLE is ignored.
- start sampled in the FIN cycle is ignored. A new start is accepted from IDLE on the following cycle.
- Exactly one strobe is high in any cycle.
- key_RC is 0 in every cycle without kexp_start or ikey_start.
- The round output reflects C, registered.
- Total latency: E0 to counter_done = 61 cycles:
  - kexp E1..E10
  - ADD0 E11
  - rounds 1-9 E12..E56, 5 cycles each
  - round 10 E57..E60, no IMIX
  - done E61

Test Plan:
- Reset, then idle 5 cycles with start=0 -> all strobes 0, key_RC=0, mux1_sel=0, mux2_sel=00, round=0, busy=0.
- start pulse at E0 -> kexp_start high E1..E10, key_RC=01000000,02000000,...,1B000000,36000000; add_start at E11 with mux1_sel=0, mux2_sel=00.
- Continue the same run:
  - round 1: ishift E12, isub E13, ikey E14 with key_RC=36000000, add E15, imix E16; mux1_sel=1, mux2_sel=01, round=1.
  - round 2: ikey at E19 with key_RC=1B000000.
- Final round:
  - ishift E57, isub E58, ikey E59 with key_RC=01000000, add E60 with mux2_sel=10 and round=10; no imix_start.
  - counter_done high only at E61; busy low from E61.
  - Across the run: 10 kexp, 11 add, 10 ishift, 10 isub, 10 ikey, 9 imix strobes.
- start held high continuously -> back-to-back runs, each with the same E0-relative timeline. The second run's E0 is the first edge where start is sampled in IDLE after FIN.
- reset_n driven low asynchronously at E30 (mid round 4), then released -> outputs go to reset values immediately. A new start yields a full, correct 61-cycle sequence from round 0.

Source files
------------

// File: rtl/decryption_counter_if.sv
// Control bundle between the AES-128 decryption sequencer and its datapath.
// The sequencer drives everything except start.
interface decryption_counter_if;
  logic        start;
  logic        kexp_start;
  logic        add_start;
  logic        ishift_start;
  logic        isub_start;
  logic        ikey_start;
  logic        imix_start;
  logic [31:0] key_RC;
  logic        mux1_sel;
  logic [1:0]  mux2_sel;
  logic [3:0]  round;
  logic        busy;
  logic        counter_done;

  modport master (
    output start,
    input  kexp_start, add_start, ishift_start, isub_start, ikey_start, imix_start,
    input  key_RC, mux1_sel, mux2_sel, round, busy, counter_done
  );

  modport slave (
    input  start,
    output kexp_start, add_start, ishift_start, isub_start, ikey_start, imix_start,
    output key_RC, mux1_sel, mux2_sel, round, busy, counter_done
  );
endinterface

// File: rtl/decryption_counter.sv
// AES-128 inverse-cipher sequencer: a forward key-expansion pre-pass to reach round key 10,
// then inverse rounds. Every output is a register loaded from the current-state decode.
module decryption_counter #(
  parameter int NUM_ROUNDS = 10,  // only 10 (AES-128) is meaningful
  parameter int CNT_W      = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  decryption_counter_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEXP, S_ADD0, S_ISHIFT, S_ISUB, S_IKEY, S_ADD, S_IMIX, S_FIN
  } state_t;

  typedef struct packed {
    logic        kexp;
    logic        add;
    logic        ishift;
    logic        isub;
    logic        ikey;
    logic        imix;
    logic [31:0] key_rc;
    logic        mux1;
    logic [1:0]  mux2;
    logic [3:0]  round;
    logic        busy;
    logic        done;
  } out_t;

  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_KEXP  = CNT_W'(NUM_ROUNDS - 1);

  // Index 0 holds rcon[1]; the key schedule walks it forward, the inverse schedule backward.
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
    case (idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1B;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] c_q, c_d;
  out_t             out_q, out_d;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      c_q     <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      out_q   <= out_d;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    out_d        = '0;
    out_d.mux1   = out_q.mux1;
    out_d.mux2   = out_q.mux2;
    out_d.round  = 4'(c_q);

    unique case (state_q)
      S_IDLE: begin
        out_d.mux1 = 1'b0;
        out_d.mux2 = 2'b00;
        if (bus.start) state_d = S_KEXP;
      end
      S_KEXP: begin
        out_d.kexp   = 1'b1;
        out_d.key_rc = {rcon(k_q), 24'h0};
        out_d.busy   = 1'b1;
        k_d          = k_q + 1'b1;
        if (k_q == LAST_KEXP) begin
          k_d     = '0;
          state_d = S_ADD0;
        end
      end
      S_ADD0: begin
        out_d.add  = 1'b1;
        out_d.mux1 = 1'b0;
        out_d.mux2 = 2'b00;
        out_d.busy = 1'b1;
        c_d        = CNT_W'(1);
        state_d    = S_ISHIFT;
      end
      S_ISHIFT: begin
        // The round-state source is chosen once per round, when InvShiftRows fires.
        out_d.ishift = 1'b1;
        out_d.mux1   = 1'b1;
        out_d.mux2   = (c_q == LAST_ROUND) ? 2'b10 : 2'b01;
        out_d.busy   = 1'b1;
        state_d      = S_ISUB;
      end
      S_ISUB: begin
        out_d.isub = 1'b1;
        out_d.busy = 1'b1;
        state_d    = S_IKEY;
      end
      S_IKEY: begin
        out_d.ikey   = 1'b1;
        out_d.key_rc = {rcon(LAST_ROUND - c_q), 24'h0};
        out_d.busy   = 1'b1;
        state_d      = S_ADD;
      end
      S_ADD: begin
        out_d.add  = 1'b1;
        out_d.busy = 1'b1;
        state_d    = (c_q == LAST_ROUND) ? S_FIN : S_IMIX;
      end
      S_IMIX: begin
        out_d.imix = 1'b1;
        out_d.busy = 1'b1;
        c_d        = c_q + 1'b1;
        state_d    = S_ISHIFT;
      end
      S_FIN: begin
        // Plaintext-valid cycle: everything else already back at its idle value.
        out_d.done  = 1'b1;
        out_d.mux1  = 1'b0;
        out_d.mux2  = 2'b00;
        out_d.round = 4'd0;
        c_d         = '0;
        k_d         = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.kexp_start   = out_q.kexp;
  assign bus.add_start    = out_q.add;
  assign bus.ishift_start = out_q.ishift;
  assign bus.isub_start   = out_q.isub;
  assign bus.ikey_start   = out_q.ikey;
  assign bus.imix_start   = out_q.imix;
  assign bus.key_RC       = out_q.key_rc;
  assign bus.mux1_sel     = out_q.mux1;
  assign bus.mux2_sel     = out_q.mux2;
  assign bus.round        = out_q.round;
  assign bus.busy         = out_q.busy;
  assign bus.counter_done = out_q.done;

endmodule

// File: tb/tb_decryption_counter.sv
// Bench for decryption_counter: every cycle is compared with a position-based model of the
// 61-cycle inverse-cipher timeline, with random idle gaps and stray start pulses.
module tb_decryption_counter;

  typedef struct packed {
    logic        kexp;
    logic        add;
    logic        ishift;
    logic        isub;
    logic        ikey;
    logic        imix;
    logic [31:0] key_rc;
    logic        mux1;
    logic [1:0]  mux2;
    logic [3:0]  round;
    logic        busy;
    logic        done;
  } obs_t;

  typedef logic [$bits(obs_t)-1:0] obs_vec_t;

  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  int         exp_cnt  [6]  = '{10, 11, 10, 10, 10, 9};

  decryption_counter_if bus ();

  decryption_counter #(.NUM_ROUNDS(10), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs during the cycle after edge E<n>; anything outside 1..61 is idle.
  function automatic obs_t model(input int n);
    obs_t e;
    int   r;
    int   ph;
    e = '0;
    if (n >= 1 && n <= 10) begin
      e.kexp   = 1'b1;
      e.key_rc = {rcon_tab[n-1], 24'h0};
    end else if (n == 11) begin
      e.add = 1'b1;
    end else if (n >= 12 && n <= 60) begin
      r       = (n - 12) / 5 + 1;
      ph      = (n - 12) % 5;
      e.mux1  = 1'b1;
      e.mux2  = (r == 10) ? 2'b10 : 2'b01;
      e.round = 4'(r);
      case (ph)
        0: e.ishift = 1'b1;
        1: e.isub   = 1'b1;
        2: begin
          e.ikey   = 1'b1;
          e.key_rc = {rcon_tab[10-r], 24'h0};
        end
        3: e.add    = 1'b1;
        default: e.imix = 1'b1;
      endcase
    end else if (n == 61) begin
      e.done = 1'b1;
    end
    e.busy = (n >= 1 && n <= 60);
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.kexp   = bus.kexp_start;
    o.add    = bus.add_start;
    o.ishift = bus.ishift_start;
    o.isub   = bus.isub_start;
    o.ikey   = bus.ikey_start;
    o.imix   = bus.imix_start;
    o.key_rc = bus.key_RC;
    o.mux1   = bus.mux1_sel;
    o.mux2   = bus.mux2_sel;
    o.round  = bus.round;
    o.busy   = bus.busy;
    o.done   = bus.counter_done;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs_vec_t'(got), obs_vec_t'(exp));
    end
  endtask

  task automatic check_cnt(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_cycles(input string name, input int len);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check($sformatf("%s idle%0d", name, i), sample(), model(-1));
    end
  endtask

  // Entered at a negedge with start=1 already driven, so the next posedge is E0.
  // stray: random start pulses mid-run (always one in the FIN sample slot); chain: keep start
  // high across E62 so the next run follows back-to-back.
  task automatic run_seq(input string name, input bit stray, input bit chain, input int last_n);
    int   cnt [6];
    obs_t o;
    foreach (cnt[i]) cnt[i] = 0;
    for (int n = 0; n <= last_n; n++) begin
      @(negedge clk);
      o = sample();
      check($sformatf("%s n=%0d", name, n), o, model(n));
      cnt[0] += int'(o.kexp);
      cnt[1] += int'(o.add);
      cnt[2] += int'(o.ishift);
      cnt[3] += int'(o.isub);
      cnt[4] += int'(o.ikey);
      cnt[5] += int'(o.imix);
      if (n == 61)    bus.start = chain;
      else if (stray) bus.start = (n == 60) || ($urandom_range(0, 3) == 0);
    end
    if (last_n == 61)
      for (int i = 0; i < 6; i++)
        check_cnt($sformatf("%s strobe_count[%0d]", name, i), cnt[i], exp_cnt[i]);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;

    // Reset state, then idle with start low.
    repeat (2) @(negedge clk);
    check("in_reset", sample(), model(-1));
    reset_n = 1'b1;
    idle_cycles("post_reset", 5);

    // Single start pulse with stray starts during the run.
    bus.start = 1'b1;
    run_seq("pulse", 1'b1, 1'b0, 61);
    idle_cycles("after_pulse", int'($urandom_range(2, 5)));

    // start held high: three runs back to back, then release.
    bus.start = 1'b1;
    run_seq("b2b0", 1'b0, 1'b1, 61);
    run_seq("b2b1", 1'b0, 1'b1, 61);
    run_seq("b2b2", 1'b0, 1'b0, 61);
    idle_cycles("after_b2b", int'($urandom_range(2, 5)));

    // Asynchronous reset at E30, in the middle of round 4.
    bus.start = 1'b1;
    run_seq("abort", 1'b1, 1'b0, 29);
    @(posedge clk);
    #2 reset_n = 1'b0;
    bus.start  = 1'b0;
    #1 check("async_reset_immediate", sample(), model(-1));
    @(negedge clk);
    check("async_reset_held", sample(), model(-1));
    reset_n = 1'b1;
    idle_cycles("after_abort", 3);

    // Full run after the abort.
    bus.start = 1'b1;
    run_seq("restart", 1'b1, 1'b0, 61);
    idle_cycles("final", 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
